// File: rtl/mmio_pkg.sv
// Shared MMIO map: addresses, field widths and the bus request bundle.
package mmio_pkg;

  localparam int XLEN  = 32;
  localparam int TX_W  = 8;
  localparam int RX_W  = 8;
  localparam int BTN_W = 3;
  localparam int SW_W  = 2;
  localparam int LED_W = 6;

  localparam logic [XLEN-1:0] MMIO_UART_CTRL = 32'h8000_0000;
  localparam logic [XLEN-1:0] MMIO_RX_DATA   = 32'h8000_0004;
  localparam logic [XLEN-1:0] MMIO_TX_DATA   = 32'h8000_0008;
  localparam logic [XLEN-1:0] MMIO_CYC_CNT   = 32'h8000_0010;
  localparam logic [XLEN-1:0] MMIO_INS_CNT   = 32'h8000_0014;
  localparam logic [XLEN-1:0] MMIO_CNT_RESET = 32'h8000_0018;
  localparam logic [XLEN-1:0] MMIO_FIFO_EMPT = 32'h8000_0020;
  localparam logic [XLEN-1:0] MMIO_FIFO_READ = 32'h8000_0024;
  localparam logic [XLEN-1:0] MMIO_SWITCHES  = 32'h8000_0028;
  localparam logic [XLEN-1:0] MMIO_LEDS      = 32'h8000_0030;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_UART_CTRL,
    SEL_RX,
    SEL_TX,
    SEL_CYC,
    SEL_INS,
    SEL_CLR,
    SEL_EMPTY,
    SEL_POP,
    SEL_SW,
    SEL_LED
  } mmio_sel_e;

  typedef struct packed {
    logic            re;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mmio_req_t;

  // Full-address decode; anything else (including unaligned hits) is unmapped.
  function automatic mmio_sel_e mmio_decode(input logic [XLEN-1:0] a);
    mmio_sel_e s;
    s = SEL_NONE;
    case (a)
      MMIO_UART_CTRL: s = SEL_UART_CTRL;
      MMIO_RX_DATA:   s = SEL_RX;
      MMIO_TX_DATA:   s = SEL_TX;
      MMIO_CYC_CNT:   s = SEL_CYC;
      MMIO_INS_CNT:   s = SEL_INS;
      MMIO_CNT_RESET: s = SEL_CLR;
      MMIO_FIFO_EMPT: s = SEL_EMPTY;
      MMIO_FIFO_READ: s = SEL_POP;
      MMIO_SWITCHES:  s = SEL_SW;
      MMIO_LEDS:      s = SEL_LED;
      default:        s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mmio_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO: dout is the current head whenever non-empty.
module sync_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so push+pop on a full FIFO both land.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO peripheral block: UART handshake, perf counters, button FIFO, LEDs, read mux.
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  addr,
  input  logic             re,
  input  logic             we,
  input  logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  rdata,
  input  logic             inst_retire,
  output logic [TX_W-1:0]  tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [RX_W-1:0]  rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [BTN_W-1:0] clean_buttons,
  input  logic [SW_W-1:0]  switches,
  output logic [LED_W-1:0] leds
);

  mmio_req_t        req;
  mmio_sel_e        sel;
  logic             rd;
  logic             wr;
  logic             cnt_clr;
  logic [XLEN-1:0]  cyc_cnt;
  logic [XLEN-1:0]  ins_cnt;
  logic [XLEN-1:0]  rd_mux;
  logic [BTN_W-1:0] btn_prev;
  logic [BTN_W-1:0] fifo_dout;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign req = '{re: re, we: we, addr: addr, wdata: wdata};
  assign sel = mmio_decode(req.addr);

  // re and we together are treated as no access at all.
  assign rd      = req.re & ~req.we;
  assign wr      = req.we & ~req.re;
  assign cnt_clr = wr & (sel == SEL_CLR);

  // Any rising bit is an event; the whole 3-bit sample is queued.
  assign fifo_push = |(clean_buttons & ~btn_prev);
  assign fifo_pop  = rd & (sel == SEL_POP) & ~fifo_empty;

  // Consume handshake rides the load itself; forced low while in reset.
  assign rx_ready = rst_n & rd & (sel == SEL_RX);

  sync_fifo #(
    .WIDTH (BTN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_btn_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (clean_buttons),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Read data selection from the current-cycle state and inputs.
  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_UART_CTRL: rd_mux = {30'b0, rx_valid, tx_ready};
      SEL_RX:        rd_mux = {24'b0, rx_data};
      SEL_CYC:       rd_mux = cyc_cnt;
      SEL_INS:       rd_mux = ins_cnt;
      SEL_EMPTY:     rd_mux = {31'b0, fifo_empty};
      SEL_POP:       rd_mux = fifo_empty ? '0 : {29'b0, fifo_dout};
      SEL_SW:        rd_mux = {30'b0, switches};
      SEL_LED:       rd_mux = {26'b0, leds};
      default:       rd_mux = '0;
    endcase
  end

  // Load data register: updates on every re, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rdata <= '0;
    else if (req.re) rdata <= req.we ? '0 : rd_mux;
  end

  // Free-running cycle and retire counters; a clear store beats the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else if (cnt_clr) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      ins_cnt <= ins_cnt + {31'b0, inst_retire};
    end
  end

  // TX: a store is accepted only when the UART is ready; tx_valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_valid <= wr & (sel == SEL_TX) & tx_ready;
      if (wr && sel == SEL_TX && tx_ready) tx_data <= req.wdata[TX_W-1:0];
    end
  end

  // LED register write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     leds <= '0;
    else if (wr && sel == SEL_LED)  leds <= req.wdata[LED_W-1:0];
  end

  // Previous button sample for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_prev <= '0;
    else        btn_prev <= clean_buttons;
  end

endmodule
